// File: rtl/mitchell_mul_arbiter.sv
// Round-robin front end sharing one Mitchell log-multiplier among NREQ
// requesters, with a two-entry registered pipeline and a tagged,
// back-pressurable response channel.

// Combinational 8x8 Mitchell approximate multiplier. A zero on either input
// forces a zero product. The result is truncated and gets no correction term.
module mitchel (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);
    logic [2:0] k_x;
    logic [2:0] k_y;
    logic [6:0] f_x;
    logic [6:0] f_y;
    logic [7:0] f_sum;
    logic [3:0] k_sum;

    // Leading-one position gives the characteristic. The bits below it,
    // left-aligned to 7 bits, are the mantissa fraction.
    always_comb begin
        k_x = 3'd0;
        k_y = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) k_x = 3'(i);
            if (y[i]) k_y = 3'(i);
        end
        f_x   = 7'(15'(x) << (3'd7 - k_x));
        f_y   = 7'(15'(y) << (3'd7 - k_y));
        f_sum = {1'b0, f_x} + {1'b0, f_y};
        k_sum = {1'b0, k_x} + {1'b0, k_y};
    end

    // Antilog. A carry out of the fraction sum bumps the exponent and uses
    // the sum itself as mantissa; otherwise the implicit leading one is restored.
    always_comb begin
        if (x == 8'd0 || y == 8'd0) begin
            p = 16'd0;
        end else if (f_sum[7]) begin
            p = 16'(({16'd0, f_sum} << k_sum) >> 6);
        end else begin
            p = 16'(({16'd0, 1'b1, f_sum[6:0]} << k_sum) >> 7);
        end
    end
endmodule

module mitchell_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_x,
    input  logic [8*NREQ-1:0] req_y,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [15:0]       resp_p,
    output logic              busy
);
    logic [IDW-1:0] ptr;
    logic           s1_valid;
    logic [7:0]     s1_x;
    logic [7:0]     s1_y;
    logic [IDW-1:0] s1_id;
    logic           s2_valid;
    logic [15:0]    s2_p;
    logic [IDW-1:0] s2_id;

    logic           s2_adv;
    logic           s1_free;
    logic           found;
    logic [IDW-1:0] win;
    logic           xfer;
    logic [15:0]    mul_p;

    mitchel u_mitchel (
        .x (s1_x),
        .y (s1_y),
        .p (mul_p)
    );

    assign s2_adv  = s1_valid & (~s2_valid | resp_ready);
    assign s1_free = ~s1_valid | s2_adv;
    assign xfer    = found & s1_free & rst_n;

    // Round-robin scan starting at ptr; the grant is gated by S1 space and
    // held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        found     = 1'b0;
        win       = '0;
        for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        if (found && rst_n) req_ready[win] = s1_free;
    end

    // Priority pointer moves just past the requester that was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (int'(win) == NREQ - 1) ? '0 : IDW'(int'(win) + 1);
        end
    end

    // Stage 1: operand capture feeding the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_id    <= '0;
        end else if (xfer) begin
            s1_valid <= 1'b1;
            s1_x     <= req_x[int'(win)*8 +: 8];
            s1_y     <= req_y[int'(win)*8 +: 8];
            s1_id    <= win;
        end else if (s1_free) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: registered product driving the response channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_id    <= '0;
        end else if (s2_adv) begin
            s2_valid <= 1'b1;
            s2_p     <= mul_p;
            s2_id    <= s1_id;
        end else if (resp_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign resp_valid = s2_valid;
    assign resp_p     = s2_p;
    assign resp_id    = s2_id;
    assign busy       = s1_valid | s2_valid;
endmodule

// File: tb/tb_mitchell_mul_arbiter.sv
// Scoreboard bench for mitchell_mul_arbiter: every accepted pair pushes its
// expected id/product, every consumed response pops and compares.
module tb_mitchell_mul_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [31:0]     req_x;
    logic [31:0]     req_y;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [15:0]     resp_p;
    logic            busy;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] p;
        int          cyc;
    } entry_t;

    entry_t      sb[$];
    int          grant_log[$];
    int          resp_log[$];
    int          resp_cyc[$];
    int          errs = 0;
    int          nchk = 0;
    int          cyc = 0;
    logic        chk_lat = 1'b1;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_p;
    logic [1:0]  prev_id;
    logic [15:0] last_p;
    logic [3:0]  last_rr;

    mitchell_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Mitchell product written as x*2^ky + y*2^kx relative to 2^(kx+ky);
    // the carry case is where the fraction sum reaches one.
    function automatic logic [15:0] model_p(input int x, input int y);
        int kx, ky, a, base;
        if (x == 0 || y == 0) return 16'd0;
        kx = 0;
        while ((2 << kx) <= x) kx++;
        ky = 0;
        while ((2 << ky) <= y) ky++;
        a    = (x << ky) + (y << kx);
        base = 1 << (kx + ky);
        if (a >= 3 * base) return 16'(2 * (a - 2 * base));
        return 16'(a - base);
    endfunction

    // Response-side checks and acceptance capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            entry_t e;
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (prev_stall) begin
                chk("stall_valid", resp_valid, 1);
                chk("stall_p", resp_p, prev_p);
                chk("stall_id", resp_id, prev_id);
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("stale_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_p", resp_p, e.p);
                    if (chk_lat) chk("latency", cyc - e.cyc, 2);
                    resp_log.push_back(int'(resp_id));
                    resp_cyc.push_back(cyc);
                    last_p = resp_p;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id  = 2'(i);
                    e.p   = model_p(int'(req_x[8*i +: 8]), int'(req_y[8*i +: 8]));
                    e.cyc = cyc;
                    sb.push_back(e);
                    grant_log.push_back(i);
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_p     = resp_p;
            prev_id    = resp_id;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_one(input int i, input logic [7:0] x, input logic [7:0] y);
        bit ok;
        @(posedge clk); #1;
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
        req_valid[i]    = 1'b1;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            last_rr = req_ready;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int g0, r0;
        rst_n      = 1'b0;
        req_valid  = 4'b0001;
        req_x      = '0;
        req_y      = '0;
        req_x[7:0] = 8'd3;
        req_y[7:0] = 8'd3;
        resp_ready = 1'b1;

        // Reset state and first product latency.
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_p", resp_p, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_busy", busy, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        chk("s1_resp_valid", resp_valid, 0);
        chk("s1_busy", busy, 1);
        @(posedge clk); #1;
        chk("first_valid", resp_valid, 1);
        chk("first_id", resp_id, 0);
        chk("first_p", resp_p, 8);
        @(posedge clk); #1;
        chk("first_idle", busy, 0);
        wait_idle();

        // Exact, saturating and zero cases; the last one leaves ptr at 0.
        send_one(1, 8'd4, 8'd4);     wait_idle(); chk("p_4x4", last_p, 16);
        send_one(2, 8'd255, 8'd255); wait_idle(); chk("p_255x255", last_p, 65024);
        send_one(3, 8'd0, 8'd200);   wait_idle(); chk("p_0x200", last_p, 0);
        send_one(3, 8'd1, 8'd1);     wait_idle(); chk("p_1x1", last_p, 1);

        // Fairness: all four held valid for eight cycles.
        g0 = grant_log.size();
        r0 = resp_log.size();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_x[8*i +: 8] = 8'($urandom_range(0, 255));
            req_y[8*i +: 8] = 8'($urandom_range(0, 255));
        end
        req_valid = 4'b1111;
        run_cycles(8);
        req_valid = 4'b0000;
        wait_idle();
        chk("rr_count", grant_log.size() - g0, 8);
        for (int k = 0; k < 8; k++) begin
            if (g0 + k < grant_log.size()) chk("rr_grant", grant_log[g0 + k], k % 4);
            if (r0 + k < resp_log.size())  chk("rr_resp_id", resp_log[r0 + k], k % 4);
            if (r0 + k > 0 && r0 + k < resp_cyc.size())
                if (k > 0) chk("rr_resp_back2back", resp_cyc[r0 + k] - resp_cyc[r0 + k - 1], 1);
        end

        // Backpressure: two accepts fill the pipe, then no more grants.
        g0 = grant_log.size();
        r0 = resp_log.size();
        chk_lat    = 1'b0;
        resp_ready = 1'b0;
        req_x[15:8]  = 8'd17;  req_y[15:8]  = 8'd9;
        req_x[23:16] = 8'd100; req_y[23:16] = 8'd3;
        req_valid  = 4'b0110;
        run_cycles(5);
        chk("bp_accepts", grant_log.size() - g0, 2);
        if (grant_log.size() >= g0 + 2) begin
            chk("bp_grant0", grant_log[g0], 1);
            chk("bp_grant1", grant_log[g0 + 1], 2);
        end
        chk("bp_full_ready", last_rr, 0);
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        wait_idle();
        chk("bp_resp_count", resp_log.size() - r0, 2);
        if (resp_log.size() >= r0 + 2) begin
            chk("bp_resp_id0", resp_log[r0], 1);
            chk("bp_resp_id1", resp_log[r0 + 1], 2);
            chk("bp_resp_gap", resp_cyc[r0 + 1] - resp_cyc[r0], 1);
        end
        chk_lat = 1'b1;

        // Pointer hold and skip: ptr is 3 here.
        send_one(3, 8'd7, 8'd5);
        req_x[23:16] = 8'd12; req_y[23:16] = 8'd12;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("skip_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_x[31:24] = 8'd2; req_y[31:24] = 8'd6;
        req_x[7:0]   = 8'd9; req_y[7:0]   = 8'd9;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("ptr_after_skip", req_ready, 4'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_idle();

        // Reset mid-operation with two entries in flight.
        resp_ready = 1'b0;
        chk_lat    = 1'b0;
        send_one(0, 8'd50, 8'd60);
        send_one(1, 8'd70, 8'd80);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        chk_lat    = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", resp_valid, 0);
        end
        @(posedge clk); #1;
        req_x[15:8] = 8'd11; req_y[15:8] = 8'd13;
        req_valid = 4'b1110;
        @(negedge clk);
        chk("post_rst_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d", errs);
        $fatal(1);
    end
endmodule
